// File: rtl/vending_session_ctrl.sv
// Session controller for the vending datapath: collects coins into a credit,
// takes one selection, issues a single request, then pays change or a refund.
module vending_session_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [7:0] coin_value,
    output logic       coin_ready,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [2:0] sel_product,
    output logic       sel_ready,
    input  logic       cancel,
    output logic [7:0] vm_cash,
    output logic [2:0] vm_product,
    input  logic [7:0] vm_change,
    input  logic       vm_success,
    output logic       ret_valid,
    output logic [7:0] ret_amount,
    input  logic       ret_ready,
    output logic       vend_done,
    output logic       vend_fail,
    output logic [7:0] credit,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_RETURN
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] ret_q, ret_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] vm_cash_q, vm_cash_d;
    logic [2:0] vm_product_q, vm_product_d;
    logic       reject_q, reject_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic [8:0] sum;
    logic [7:0] change_clamped;

    // Handshake readies are gated by reset so every output reads 0 while it is held.
    assign coin_ready = reset && (state_q == S_IDLE || state_q == S_COLLECT) && !cancel;
    assign sel_ready  = reset && (state_q == S_COLLECT) && !coin_valid && !cancel;

    assign sum            = {1'b0, credit_q} + {1'b0, coin_value};
    assign change_clamped = (vm_change < credit_q) ? vm_change : credit_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d      = state_q;
        credit_d     = credit_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        vm_cash_d    = '0;
        vm_product_d = '0;
        reject_d     = 1'b0;
        done_d       = 1'b0;
        fail_d       = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_COLLECT && cancel) begin
                    ret_d   = credit_q;
                    state_d = S_RETURN;
                end else if (coin_valid && coin_ready) begin
                    if (sum[8]) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[7:0];
                        if (sum[7:0] != 8'd0) state_d = S_COLLECT;
                    end
                end else if (sel_valid && sel_ready && sel_product != 3'd0) begin
                    vm_product_d = sel_product;
                    vm_cash_d    = credit_q;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d     = '0;
                vm_cash_d = credit_q;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Success is checked first so it wins over the last timeout cycle.
                if (vm_success) begin
                    done_d = 1'b1;
                    ret_d  = change_clamped;
                    if (change_clamped != 8'd0) begin
                        state_d = S_RETURN;
                    end else begin
                        credit_d = '0;
                        state_d  = S_IDLE;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    fail_d  = 1'b1;
                    ret_d   = credit_q;
                    state_d = S_RETURN;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    vm_cash_d = credit_q;
                end
            end
            S_RETURN: begin
                if (ret_ready) begin
                    credit_d = '0;
                    ret_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset clears it asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            credit_q     <= '0;
            ret_q        <= '0;
            cnt_q        <= '0;
            vm_cash_q    <= '0;
            vm_product_q <= '0;
            reject_q     <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            vm_cash_q    <= vm_cash_d;
            vm_product_q <= vm_product_d;
            reject_q     <= reject_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign coin_reject = reject_q;
    assign vm_cash     = vm_cash_q;
    assign vm_product  = vm_product_q;
    assign ret_valid   = (state_q == S_RETURN);
    assign ret_amount  = ret_q;
    assign vend_done   = done_q;
    assign vend_fail   = fail_q;
    assign credit      = credit_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_RETURN);

endmodule

// File: tb/tb_vending_session_ctrl.sv
// Bench for vending_session_ctrl: directed scenarios then random traffic, all
// outputs compared every cycle against a flag-based session model.
module tb_vending_session_ctrl;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_product = '0;
    logic       cancel = 1'b0;
    logic [7:0] vm_change = '0;
    logic       vm_success = 1'b0;
    logic       ret_ready = 1'b0;
    logic       coin_ready, coin_reject, sel_ready, ret_valid, vend_done, vend_fail, busy;
    logic [7:0] vm_cash, ret_amount, credit;
    logic [2:0] vm_product;

    always #5 clock = ~clock;

    vending_session_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
        .coin_reject(coin_reject), .sel_valid(sel_valid), .sel_product(sel_product),
        .sel_ready(sel_ready), .cancel(cancel), .vm_cash(vm_cash), .vm_product(vm_product),
        .vm_change(vm_change), .vm_success(vm_success), .ret_valid(ret_valid),
        .ret_amount(ret_amount), .ret_ready(ret_ready), .vend_done(vend_done),
        .vend_fail(vend_fail), .credit(credit), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Session model: credit plus "what is the session doing" flags.
    int m_credit, m_ret, m_prod, m_age;
    bit m_issuing, m_waiting, m_returning, m_rej, m_done, m_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_ret = 0; m_prod = 0; m_age = 0;
        m_issuing = 0; m_waiting = 0; m_returning = 0;
        m_rej = 0; m_done = 0; m_fail = 0;
    endtask

    task automatic model_step();
        int ch;
        m_rej = 0; m_done = 0; m_fail = 0;
        if (!(m_issuing || m_waiting || m_returning)) begin
            if (cancel) begin
                if (m_credit > 0) begin m_returning = 1; m_ret = m_credit; end
            end else if (coin_valid) begin
                if (m_credit + int'(coin_value) > 255) m_rej = 1;
                else m_credit += int'(coin_value);
            end else if (sel_valid && m_credit > 0 && sel_product != 0) begin
                m_issuing = 1; m_prod = int'(sel_product);
            end
        end else if (m_issuing) begin
            m_issuing = 0; m_waiting = 1; m_age = 0;
        end else if (m_waiting) begin
            if (vm_success) begin
                m_done = 1; m_waiting = 0;
                ch = (int'(vm_change) < m_credit) ? int'(vm_change) : m_credit;
                if (ch > 0) begin m_returning = 1; m_ret = ch; end
                else m_credit = 0;
            end else if (m_age == T - 1) begin
                m_fail = 1; m_waiting = 0; m_returning = 1; m_ret = m_credit;
            end else begin
                m_age++;
            end
        end else if (ret_ready) begin
            m_returning = 0; m_ret = 0; m_credit = 0;
        end
    endtask

    task automatic compare_all();
        bit open, rs;
        open = !(m_issuing || m_waiting || m_returning);
        rs   = (reset === 1'b1);
        check("coin_ready", 32'(coin_ready), 32'(rs && open && !cancel));
        check("sel_ready", 32'(sel_ready), 32'(rs && open && m_credit > 0 && !coin_valid && !cancel));
        check("coin_reject", 32'(coin_reject), 32'(m_rej));
        check("vm_cash", 32'(vm_cash), (m_issuing || m_waiting) ? m_credit : 0);
        check("vm_product", 32'(vm_product), m_issuing ? m_prod : 0);
        check("ret_valid", 32'(ret_valid), 32'(m_returning));
        check("ret_amount", 32'(ret_amount), m_ret);
        check("vend_done", 32'(vend_done), 32'(m_done));
        check("vend_fail", 32'(vend_fail), 32'(m_fail));
        check("credit", 32'(credit), m_credit);
        check("busy", 32'(busy), 32'(!open));
    endtask

    task automatic drive(input logic cv, input logic [7:0] cval, input logic sv,
                         input logic [2:0] sp, input logic can, input logic succ,
                         input logic [7:0] chg, input logic rr);
        @(negedge clock);
        coin_valid = cv; coin_value = cval; sel_valid = sv; sel_product = sp;
        cancel = can; vm_success = succ; vm_change = chg; ret_ready = rr;
        #1 compare_all();
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
    endtask

    task automatic cyc(input logic cv, input logic [7:0] cval, input logic sv,
                       input logic [2:0] sp, input logic can, input logic succ,
                       input logic [7:0] chg, input logic rr);
        drive(cv, cval, sv, sp, can, succ, chg, rr);
        tick();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #1 compare_all();
        #16 @(negedge clock) reset = 1'b1;
        idle();

        // Coin 20, select 1, success with change 5 on the 2nd WAIT cycle.
        cyc(1, 20, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_vm_product", 32'(vm_product), 1);
        check("t1_vm_cash", 32'(vm_cash), 20);
        tick();
        idle();
        cyc(0, 0, 0, 0, 0, 1, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("t1_done", 32'(vend_done), 1);
        check("t1_ret", 32'(ret_amount), 5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_credit0", 32'(credit), 0);
        tick();

        // Coin 100, select 3, datapath silent: full refund after T WAIT cycles.
        cyc(1, 100, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 0, 0, 0, 0);
        idle();
        repeat (T - 1) idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_no_early_fail", 32'(vend_fail), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("t2_fail", 32'(vend_fail), 1);
        check("t2_ret", 32'(ret_amount), 100);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_ret_valid_drop", 32'(ret_valid), 0);
        tick();

        // Overflow reject, then fill to 255; cancel to clear.
        cyc(1, 200, 0, 0, 0, 0, 0, 0);
        cyc(1, 100, 0, 0, 0, 0, 0, 0);
        drive(1, 55, 0, 0, 0, 0, 0, 0);
        check("t3_reject", 32'(coin_reject), 1);
        check("t3_credit200", 32'(credit), 200);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        check("t3_credit255", 32'(credit), 255);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("t3_refund", 32'(ret_amount), 255);
        tick();

        // Cancel beats a simultaneous coin and selection.
        cyc(1, 50, 0, 0, 0, 0, 0, 0);
        drive(1, 10, 1, 1, 1, 0, 0, 0);
        check("t4_coin_ready", 32'(coin_ready), 0);
        check("t4_sel_ready", 32'(sel_ready), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("t4_ret", 32'(ret_amount), 50);
        check("t4_no_strobe", 32'(vm_product), 0);
        tick();

        // Change larger than credit is clamped; product code 0 is ignored.
        cyc(1, 10, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 1, 30, 0);
        cyc(0, 0, 0, 0, 0, 1, 30, 0);
        cyc(0, 0, 0, 0, 0, 1, 30, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("t5_clamp", 32'(ret_amount), 10);
        tick();
        cyc(1, 7, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_sel0_busy", 32'(busy), 0);
        check("t5_sel0_credit", 32'(credit), 7);
        tick();
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset mid-WAIT, then mid-RETURN.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                cyc(1, 40, 0, 0, 0, 0, 0, 0);
                cyc(0, 0, 1, 2, 0, 0, 0, 0);
                idle();
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                cyc(1, 30, 0, 0, 0, 0, 0, 0);
                cyc(0, 0, 0, 0, 1, 0, 0, 0);
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            end
            #2 reset = 1'b0;
            #1 model_reset();
            compare_all();
            check("rst_async_busy", 32'(busy), 0);
            @(posedge clock);
            @(negedge clock) reset = 1'b1;
            #1 compare_all();
            check("rst_credit0", 32'(credit), 0);
            tick();
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) < 40,
                ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < 35,
                3'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 15,
                ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < 50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
